esa32_carry_sequencer: RTL and testbench

// - Multi-cycle controller around a 32-bit equal-segmentation adder (ESA) datapath.
// - Each accepted operand pair is summed segment-wise with inter-segment carries dropped (approximate result).
// - In exact mode, the dropped carries are then rippled one segment boundary per cycle until none remain.
// - Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.

---
 rtl/esa_pkg.sv | 22 ++
 rtl/esa_segment_add.sv | 20 ++
 rtl/esa32_carry_sequencer.sv | 140 ++++++++++++++
 tb/tb_esa32_carry_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/esa_pkg.sv
// Shared types and helpers for the ESA carry sequencer: FSM state encoding,
// default segment width and a reference segment adder.
package esa_pkg;

    localparam int unsigned DEFAULT_SEG_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FIX,
        DONE
    } state_t;

    // {cout, sum} of two DEFAULT_SEG_W-bit segments plus carry-in.
    function automatic logic [DEFAULT_SEG_W:0] seg_add(
        input logic [DEFAULT_SEG_W-1:0] a,
        input logic [DEFAULT_SEG_W-1:0] b,
        input logic                     cin
    );
        return {1'b0, a} + {1'b0, b} + {{DEFAULT_SEG_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/esa_segment_add.sv
// Single SEG_W-bit segment adder with carry-in and carry-out.
module esa_segment_add
    import esa_pkg::*;
#(
    parameter int unsigned SEG_W = DEFAULT_SEG_W
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);

    if (SEG_W == DEFAULT_SEG_W) begin : g_pkg_add
        assign {cout_o, sum_o} = seg_add(a_i, b_i, cin_i);
    end else begin : g_gen_add
        assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
    end

endmodule

// File: rtl/esa32_carry_sequencer.sv
// Multi-cycle equal-segmentation adder: carry-free segment sums on accept, then optional
// one-boundary-per-cycle carry ripple in exact mode. Valid/ready on both sides.
module esa32_carry_sequencer
    import esa_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = DEFAULT_SEG_W,
    localparam int unsigned NUM_SEG = WIDTH / SEG_W,
    localparam int unsigned CNT_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o,
    output logic             err_o,
    output logic [CNT_W-1:0] corr_cnt_o
);

    if ((WIDTH % SEG_W) != 0 || NUM_SEG < 2) begin : g_bad_params
        $error("esa32_carry_sequencer: WIDTH must be a multiple of SEG_W with at least 2 segments");
    end

    // Carries out of segments 0..NUM_SEG-2; the top carry is the real carry-out, never dropped.
    localparam logic [NUM_SEG-1:0] INNER = {1'b0, {(NUM_SEG - 1){1'b1}}};
    localparam logic [CNT_W-1:0]   K_LAST = CNT_W'(NUM_SEG - 2);

    state_t                         state_q, state_d;
    logic [NUM_SEG-1:0][SEG_W-1:0]  seg_q, seg_d;
    logic [NUM_SEG-1:0]             c_q, c_d;
    logic                           mode_q, mode_d;
    logic [CNT_W-1:0]               k_q, k_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic [NUM_SEG-1:0][SEG_W-1:0]  ld_sum;
    logic [NUM_SEG-1:0]             ld_c;
    logic [SEG_W-1:0]               fix_sum;
    logic                           fix_cout;
    logic [CNT_W-1:0]               k_nxt;
    logic [NUM_SEG-1:0]             hi_mask;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_load
        esa_segment_add #(
            .SEG_W (SEG_W)
        ) u_seg_add (
            .a_i    (add1_i[k*SEG_W +: SEG_W]),
            .b_i    (add2_i[k*SEG_W +: SEG_W]),
            .cin_i  (1'b0),
            .sum_o  (ld_sum[k]),
            .cout_o (ld_c[k])
        );
    end

    assign k_nxt   = k_q + 1'b1;
    assign hi_mask = {NUM_SEG{1'b1}} << k_nxt;

    // Shared correction adder: folds the pending carry of segment k into segment k+1.
    esa_segment_add #(
        .SEG_W (SEG_W)
    ) u_fix_add (
        .a_i    (seg_q[k_nxt]),
        .b_i    ({SEG_W{1'b0}}),
        .cin_i  (c_q[k_q]),
        .sum_o  (fix_sum),
        .cout_o (fix_cout)
    );

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        c_d     = c_q;
        mode_d  = mode_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    seg_d  = ld_sum;
                    c_d    = ld_c;
                    mode_d = mode_i;
                    k_d    = '0;
                    cnt_d  = '0;
                    if (!mode_i || (ld_c & INNER) == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                seg_d[k_nxt] = fix_sum;
                c_d[k_nxt]   = c_q[k_nxt] | fix_cout;
                c_d[k_q]     = 1'b0;
                cnt_d        = cnt_q + 1'b1;
                // Carries below k+1 are already resolved, so only the ones above matter.
                if ((c_d & INNER & hi_mask) == '0 || k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_nxt;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            seg_q   <= '0;
            c_q     <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign result_o   = {c_q[NUM_SEG-1], seg_q};
    assign err_o      = !mode_q && ((c_q & INNER) != '0);
    assign corr_cnt_o = cnt_q;

endmodule

// File: tb/tb_esa32_carry_sequencer.sv
// Directed and random checks of the ESA carry sequencer with immediate assertions.
module tb_esa32_carry_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mode = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [32:0] result;
    logic        err;
    logic [1:0]  corr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    esa32_carry_sequencer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_in),
        .ready_o    (ready_out),
        .add1_i     (a),
        .add2_i     (b),
        .mode_i     (mode),
        .valid_o    (valid_out),
        .ready_i    (ready_in),
        .result_o   (result),
        .err_o      (err),
        .corr_cnt_o (corr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Present one operand pair, return cycles from accept edge to valid_o (bounded).
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic m,
                          output int lat);
        @(negedge clk);
        a        = x;
        b        = y;
        mode     = m;
        valid_in = 1'b1;
        check("ready_before_accept", 33'(ready_out), 33'(1));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        check("valid_drops_after_take", 33'(valid_out), 33'(0));
        check("ready_back_after_take", 33'(ready_out), 33'(1));
    endtask

    initial begin
        int          lat;
        int          accepts;
        int          valids;
        logic [32:0] held;
        logic [31:0] x;
        logic [31:0] y;

        // Reset state
        #12;
        check("rst_ready", 33'(ready_out), 33'(1));
        check("rst_valid", 33'(valid_out), 33'(0));
        check("rst_result", result, 33'(0));
        check("rst_err", 33'(err), 33'(0));
        check("rst_cnt", 33'(corr_cnt), 33'(0));
        @(negedge clk);
        rst = 1'b0;

        // T1: reset during FIX step 1
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; mode = 1'b1; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t1_in_fix_cnt", 33'(corr_cnt), 33'(1));
        check("t1_busy", 33'(ready_out), 33'(0));
        #2;
        rst = 1'b1;
        #1;
        check("t1_async_ready", 33'(ready_out), 33'(1));
        check("t1_async_valid", 33'(valid_out), 33'(0));
        check("t1_async_result", result, 33'(0));
        check("t1_async_cnt", 33'(corr_cnt), 33'(0));
        @(negedge clk);
        rst = 1'b0;

        // T2: approximate, carries dropped
        run_op(32'h8943_DEAF, 32'hDAAD_BAAD, 1'b0, lat);
        check("t2_latency", 33'(lat), 33'(1));
        check("t2_result", result, 33'h1_63F0_985C);
        check("t2_err", 33'(err), 33'(1));
        check("t2_cnt", 33'(corr_cnt), 33'(0));
        take_result();
        check("t2_result_kept", result, 33'h1_63F0_985C);

        // T3: exact, early exit
        run_op(32'h8943_DEAF, 32'hDAAD_BAAD, 1'b1, lat);
        check("t3_latency", 33'(lat), 33'(3));
        check("t3_result", result, 33'h1_63F1_995C);
        check("t3_err", 33'(err), 33'(0));
        check("t3_cnt", 33'(corr_cnt), 33'(2));
        take_result();

        // T4: exact full ripple, then the same pair approximate
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, lat);
        check("t4_latency", 33'(lat), 33'(4));
        check("t4_result", result, 33'h1_0000_0000);
        check("t4_err", 33'(err), 33'(0));
        check("t4_cnt", 33'(corr_cnt), 33'(3));
        take_result();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("t4a_latency", 33'(lat), 33'(1));
        check("t4a_result", result, 33'h0_FFFF_FF00);
        check("t4a_err", 33'(err), 33'(1));
        check("t4a_cnt", 33'(corr_cnt), 33'(0));
        take_result();

        // T5: no carries, both modes
        for (int m = 0; m < 2; m++) begin
            run_op(32'h29AF_2430, 32'h7A1B_9ABC, m[0], lat);
            check("t5_latency", 33'(lat), 33'(1));
            check("t5_result", result, 33'h0_A3CA_BEEC);
            check("t5_err", 33'(err), 33'(0));
            check("t5_cnt", 33'(corr_cnt), 33'(0));
            take_result();
        end

        // T6a: consumer stall with a competing valid_i
        run_op(32'h8943_DEAF, 32'hDAAD_BAAD, 1'b0, lat);
        held = 33'h1_63F0_985C;
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; mode = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_stall_valid", 33'(valid_out), 33'(1));
            check("t6_stall_ready", 33'(ready_out), 33'(0));
            check("t6_stall_result", result, held);
            check("t6_stall_err", 33'(err), 33'(1));
        end
        valid_in = 1'b0;
        take_result();
        check("t6_no_accept", result, held);

        // T6b: back-to-back, one accept every 2 cycles
        @(negedge clk);
        a = 32'h0102_0304; b = 32'h1010_1010; mode = 1'b0;
        valid_in = 1'b1; ready_in = 1'b1;
        accepts = 0; valids = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready_out) accepts++;
            if (valid_out) valids++;
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("t6_b2b_accepts", 33'(accepts), 33'(5));
        check("t6_b2b_valids", 33'(valids), 33'(5));
        check("t6_b2b_result", result, 33'h0_1112_1314);
        @(negedge clk);
        ready_in = 1'b0;
        check("t6_b2b_idle", 33'(ready_out), 33'(1));

        // T6c: random exact-mode scoreboard
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            run_op(x, y, 1'b1, lat);
            check("rnd_result", result, {1'b0, x} + {1'b0, y});
            check("rnd_err", 33'(err), 33'(0));
            check("rnd_latency_bound", 33'(lat <= 4), 33'(1));
            take_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
